rst_seq_ctrl: RTL and testbench
===============================

Name: rst_seq_ctrl

Overview:
Parametrised reset sequencer and run-window controller for the Minisopc family.
- Holds a multi-domain SoC (CPU core, inst ROM, data RAM, peripherals) in reset for a programmable number of cycles.
- Releases each domain's reset in a staggered order.
- Counts run cycles and flags completion after a programmable budget.
- Replaces ad-hoc fixed-delay reset release; usable in synthesis and simulation tops.

Parameters:
NUM_CH, 4, number of reset domains driven (1..16)
RST_CYCLES, 10, cycles all channels stay asserted after rst deasserts (>=1)
STAGGER, 2, cycles between consecutive channel releases (0 = all release together)
RUN_CYCLES, 50, run-cycle budget before run_done; 0 = unlimited
CNT_W, 32, width of cycle_cnt

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous, active-high reset
restart_req  input  1  single-cycle pulse: restart the full sequence
hold  input  1  freeze run counting (see Optional Feature)
ch_rst  output  NUM_CH  per-domain reset, active-high (1 = RstEnable); bit 0 releases first
cycle_cnt  output  CNT_W  run cycles elapsed since the last channel released
running  output  1  high in RUN state
run_done  output  1  sticky high in DONE state
state  output  2  current state: 0 RESET, 1 RELEASE, 2 RUN, 3 DONE

Behaviour:
- rst high (synchronous): state=RESET, ch_rst all ones, cycle_cnt=0, running=0, run_done=0, internal timer=0. Takes priority over everything, including mid-sequence.
- RESET: timer increments each cycle after rst is low. When timer==RST_CYCLES-1: go to RELEASE, timer=0. ch_rst stays all ones for exactly RST_CYCLES cycles after the first cycle with rst low.
- RELEASE: ch_rst[i] clears on the cycle where timer==STAGGER*i; bit 0 clears on the first RELEASE cycle.
  - Transition to RUN occurs in the same cycle that ch_rst[NUM_CH-1] clears.
  - STAGGER=0: all bits clear together and RELEASE lasts one cycle.
  - Released bits never reassert except via rst or restart_req.
- RUN: running=1; cycle_cnt increments by 1 per cycle.
  - RUN_CYCLES!=0: when cycle_cnt==RUN_CYCLES-1, the next state is DONE and cycle_cnt becomes RUN_CYCLES.
  - RUN_CYCLES==0: never leaves RUN; cycle_cnt saturates at all ones (no wrap).
- DONE: run_done=1, running=0, cycle_cnt frozen. ch_rst stays all zeros; the SoC keeps running, and run_done is only a flag.
- restart_req (rst low), in any state: next cycle state=RESET, ch_rst all ones, cycle_cnt=0, run_done=0, timer=0. The full RST_CYCLES count then restarts. restart_req while already in RESET also restarts the timer.
- Simultaneous rst and restart_req: rst wins; result is identical.
- All outputs are registered; no combinational path from input to output.

Optional Feature:
Macro RSQ_HOLD_EN.
- Defined: while hold=1 in RUN, cycle_cnt and the RUN_CYCLES comparison freeze. ch_rst is unaffected. hold is ignored in all other states.
- Undefined: the hold port exists but is ignored; behaviour is identical to hold=0.

Decomposition:
Shared package / Defines include:
- State encodings RSQ_RESET/RELEASE/RUN/DONE.
- Reset level constants RstEnable=1, RstDisable=0.
- A state width constant.

Sub-module rsq_timer: a loadable up-counter with clear, enable and terminal-compare output. It is instanced once for the RESET/RELEASE timer and once for cycle_cnt (saturating mode).

Test Plan:
- Defaults; rst high 5 cycles then low -> ch_rst=4'b1111 for 10 cycles. Then bits clear at release cycles 0, 2, 4, 6. state=RUN on the cycle ch_rst=0.
- Defaults, run on -> cycle_cnt reaches 50; run_done=1 and state=3 on the cycle after cycle_cnt reads 49. Values stay frozen for 20 further cycles.
- restart_req pulse at RUN cycle 20 -> next cycle ch_rst=4'b1111, cycle_cnt=0, run_done=0. The full sequence repeats with identical timing.
- rst asserted during RELEASE with ch_rst=4'b1100 -> next cycle ch_rst=4'b1111 and state=0. After rst release, RST_CYCLES=10 is counted afresh.
- STAGGER=0, RUN_CYCLES=0, CNT_W=4 -> all channels clear together; cycle_cnt saturates at 15 and run_done never asserts.
- RSQ_HOLD_EN defined, hold=1 for 7 cycles mid-RUN -> run_done delayed by exactly 7 cycles. With the macro undefined, hold has no effect.

Source files
------------

// File: rtl/rst_seq_ctrl_pkg.sv
// Shared definitions for the reset sequencer: state encoding, reset levels and
// the per-channel release helper.
package rst_seq_ctrl_pkg;

    localparam int STATE_W = 2;

    localparam logic RstEnable  = 1'b1;
    localparam logic RstDisable = 1'b0;

    typedef enum logic [STATE_W-1:0] {
        RSQ_RESET   = 2'd0,
        RSQ_RELEASE = 2'd1,
        RSQ_RUN     = 2'd2,
        RSQ_DONE    = 2'd3
    } rsq_state_e;

    // Channel idx is still held in reset while rel_idx has not reached its slot.
    function automatic logic ch_held(input int stagger, input int idx, input int rel_idx);
        return ((stagger * idx) > rel_idx) ? RstEnable : RstDisable;
    endfunction

endpackage

// File: rtl/rst_seq_ctrl_timer.sv
// Loadable up-counter with clear, enable and terminal-compare output; optional
// saturation at all ones (used for the sequence timer and the run-cycle counter).
module rst_seq_ctrl_timer
    import rst_seq_ctrl_pkg::*;
#(
    parameter int W   = 8,
    parameter bit SAT = 1'b0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    input  logic [W-1:0] term_val,
    output logic [W-1:0] cnt,
    output logic         at_term
);

    logic [W-1:0] cnt_d;
    logic [W-1:0] cnt_q;

    // Next count: clear beats load beats increment; saturating mode stops at all ones.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (load) begin
            cnt_d = load_val;
        end else if (en && !(SAT && (&cnt_q))) begin
            cnt_d = cnt_q + W'(1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Count register.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt     = cnt_q;
    assign at_term = (cnt_q == term_val);

endmodule

// File: rtl/rst_seq_ctrl.sv
// Reset sequencer and run-window controller: staggered per-domain reset release
// followed by a budgeted run window. Optional macro RSQ_HOLD_EN enables hold.
module rst_seq_ctrl
    import rst_seq_ctrl_pkg::*;
#(
    parameter int NUM_CH     = 4,
    parameter int RST_CYCLES = 10,
    parameter int STAGGER    = 2,
    parameter int RUN_CYCLES = 50,
    parameter int CNT_W      = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               restart_req,
    input  logic               hold,
    output logic [NUM_CH-1:0]  ch_rst,
    output logic [CNT_W-1:0]   cycle_cnt,
    output logic               running,
    output logic               run_done,
    output logic [STATE_W-1:0] state
);

    localparam int LAST_REL = STAGGER * (NUM_CH - 1);
    localparam int TMR_MAX  = (RST_CYCLES > LAST_REL) ? RST_CYCLES : LAST_REL;
    localparam int TMR_W    = $clog2(TMR_MAX + 1);

    localparam logic [TMR_W-1:0] RST_TERM = TMR_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] RUN_TERM = (RUN_CYCLES == 0) ? '0 : CNT_W'(RUN_CYCLES - 1);

`ifdef RSQ_HOLD_EN
    localparam logic HOLD_EN = 1'b1;
`else
    localparam logic HOLD_EN = 1'b0;
`endif

    rsq_state_e        state_d;
    rsq_state_e        state_q;
    logic [NUM_CH-1:0] ch_rst_d;
    logic [NUM_CH-1:0] ch_rst_q;
    logic              running_d;
    logic              running_q;
    logic              run_done_d;
    logic              run_done_q;

    logic              tmr_clr;
    logic              tmr_en;
    logic [TMR_W-1:0]  tmr_cnt;
    logic              tmr_at_term;
    logic              cyc_clr;
    logic              cyc_en;
    logic [CNT_W-1:0]  cyc_cnt;
    logic              cyc_at_term;
    logic              hold_eff;
    int                rel_next;

    assign hold_eff = hold & HOLD_EN;

    rst_seq_ctrl_timer #(
        .W   (TMR_W),
        .SAT (1'b0)
    ) u_seq_tmr (
        .clk      (clk),
        .rst      (rst),
        .clr      (tmr_clr),
        .load     (1'b0),
        .load_val ({TMR_W{1'b0}}),
        .en       (tmr_en),
        .term_val (RST_TERM),
        .cnt      (tmr_cnt),
        .at_term  (tmr_at_term)
    );

    rst_seq_ctrl_timer #(
        .W   (CNT_W),
        .SAT (1'b1)
    ) u_run_cnt (
        .clk      (clk),
        .rst      (rst),
        .clr      (cyc_clr),
        .load     (1'b0),
        .load_val ({CNT_W{1'b0}}),
        .en       (cyc_en),
        .term_val (RUN_TERM),
        .cnt      (cyc_cnt),
        .at_term  (cyc_at_term)
    );

    // Next-state, channel release pattern and timer controls.
    always_comb begin
        state_d  = state_q;
        ch_rst_d = ch_rst_q;
        tmr_clr  = 1'b0;
        tmr_en   = 1'b0;
        cyc_clr  = 1'b0;
        cyc_en   = 1'b0;
        rel_next = int'(tmr_cnt) + 32'sd1;

        if (restart_req) begin
            state_d  = RSQ_RESET;
            ch_rst_d = {NUM_CH{RstEnable}};
            tmr_clr  = 1'b1;
            cyc_clr  = 1'b1;
        end else begin
            case (state_q)
                RSQ_RESET: begin
                    cyc_clr  = 1'b1;
                    ch_rst_d = {NUM_CH{RstEnable}};
                    if (tmr_at_term) begin
                        // Entering release index 0: bit 0 (and any zero-stagger bits) drop now.
                        tmr_clr = 1'b1;
                        for (int i = 0; i < NUM_CH; i++) begin
                            ch_rst_d[i] = ch_held(STAGGER, i, 0);
                        end
                        state_d = (LAST_REL == 0) ? RSQ_RUN : RSQ_RELEASE;
                    end else begin
                        tmr_en = 1'b1;
                    end
                end
                RSQ_RELEASE: begin
                    cyc_clr = 1'b1;
                    tmr_en  = 1'b1;
                    for (int i = 0; i < NUM_CH; i++) begin
                        ch_rst_d[i] = ch_rst_q[i] & ch_held(STAGGER, i, rel_next);
                    end
                    if (rel_next >= LAST_REL) begin
                        state_d = RSQ_RUN;
                        tmr_clr = 1'b1;
                    end else begin
                        state_d = RSQ_RELEASE;
                    end
                end
                RSQ_RUN: begin
                    if (!hold_eff) begin
                        cyc_en = 1'b1;
                        if ((RUN_CYCLES != 0) && cyc_at_term) begin
                            state_d = RSQ_DONE;
                        end else begin
                            state_d = RSQ_RUN;
                        end
                    end else begin
                        cyc_en = 1'b0;
                    end
                end
                RSQ_DONE: begin
                    state_d = RSQ_DONE;
                end
                default: begin
                    state_d  = RSQ_RESET;
                    ch_rst_d = {NUM_CH{RstEnable}};
                    tmr_clr  = 1'b1;
                    cyc_clr  = 1'b1;
                end
            endcase
        end

        running_d  = (state_d == RSQ_RUN);
        run_done_d = (state_d == RSQ_DONE);
    end

    // State and output registers; rst overrides restart and every state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= RSQ_RESET;
            ch_rst_q   <= {NUM_CH{RstEnable}};
            running_q  <= 1'b0;
            run_done_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            ch_rst_q   <= ch_rst_d;
            running_q  <= running_d;
            run_done_q <= run_done_d;
        end
    end

    assign ch_rst    = ch_rst_q;
    assign cycle_cnt = cyc_cnt;
    assign running   = running_q;
    assign run_done  = run_done_q;
    assign state     = state_q;

endmodule

// File: tb/tb_rst_seq_ctrl.sv
// Scoreboard bench for rst_seq_ctrl: default instance plus a STAGGER=0 /
// unlimited-run / 4-bit counter instance, driven with the same rst/restart vectors.
module tb_rst_seq_ctrl;

`ifdef RSQ_HOLD_EN
    localparam bit HOLD_EN = 1'b1;
`else
    localparam bit HOLD_EN = 1'b0;
`endif

    localparam int NSTEPS = 290;
    localparam int BIG    = 32'h7fff_ffff;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        restart_req;
    logic        hold;

    logic [3:0]  ch_a;
    logic [31:0] cnt_a;
    logic        run_a;
    logic        done_a;
    logic [1:0]  st_a;

    logic [3:0]  ch_b;
    logic [3:0]  cnt_b;
    logic        run_b;
    logic        done_b;
    logic [1:0]  st_b;

    rst_seq_ctrl #(
        .NUM_CH(4), .RST_CYCLES(10), .STAGGER(2), .RUN_CYCLES(50), .CNT_W(32)
    ) dut_a (
        .clk(clk), .rst(rst), .restart_req(restart_req), .hold(hold),
        .ch_rst(ch_a), .cycle_cnt(cnt_a), .running(run_a), .run_done(done_a), .state(st_a)
    );

    rst_seq_ctrl #(
        .NUM_CH(4), .RST_CYCLES(10), .STAGGER(0), .RUN_CYCLES(0), .CNT_W(4)
    ) dut_b (
        .clk(clk), .rst(rst), .restart_req(restart_req), .hold(1'b0),
        .ch_rst(ch_b), .cycle_cnt(cnt_b), .running(run_b), .run_done(done_b), .state(st_b)
    );

    typedef struct {
        int         step;
        logic [1:0] st_a;
        logic [3:0] ch_a;
        int         cnt_a;
        logic [1:0] st_b;
        logic [3:0] ch_b;
        int         cnt_b;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    // Expected outputs k cycles after the last rst/restart edge, with 'held' frozen run cycles.
    function automatic void calc(input int k, input int held, input int stg, input int runc,
                                 input int cmax, output logic [1:0] st, output logic [3:0] ch,
                                 output int cnt);
        int r;
        int c;
        int last;
        last = stg * 3;
        st   = 2'd0;
        ch   = 4'b1111;
        cnt  = 0;
        if (k >= 10) begin
            r = k - 10;
            if (r < last) begin
                st = 2'd1;
                for (int i = 0; i < 4; i++) ch[i] = ((stg * i) > r);
            end else begin
                ch = 4'b0000;
                c  = r - last - held;
                if (runc != 0 && c >= runc) begin
                    st  = 2'd3;
                    cnt = runc;
                end else begin
                    st  = 2'd2;
                    cnt = (c > cmax) ? cmax : c;
                end
            end
        end
    endfunction

    task automatic check(input string name, input int step, input longint act, input longint exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s step %0d: got %0d expected %0d", name, step, act, exp);
    endtask

    // Monitor: compares every DUT output once per cycle against the queued expectation.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                check("state_a",    e.step, st_a,            e.st_a);
                check("ch_rst_a",   e.step, ch_a,            e.ch_a);
                check("cycle_a",    e.step, longint'(cnt_a), e.cnt_a);
                check("running_a",  e.step, run_a,           (e.st_a == 2'd2));
                check("run_done_a", e.step, done_a,          (e.st_a == 2'd3));
                check("state_b",    e.step, st_b,            e.st_b);
                check("ch_rst_b",   e.step, ch_b,            e.ch_b);
                check("cycle_b",    e.step, longint'(cnt_b), e.cnt_b);
                check("running_b",  e.step, run_b,           (e.st_b == 2'd2));
                check("run_done_b", e.step, done_b,          (e.st_b == 2'd3));
            end
        end
    end

    // Driver: step n sets the inputs sampled at edge n and queues the outputs expected after it.
    initial begin
        int         k;
        int         held;
        logic [1:0] st;
        logic [3:0] ch;
        int         cnt;
        exp_t       e;
        k    = 0;
        held = 0;
        rst = 1'b1;
        restart_req = 1'b0;
        hold = 1'b0;
        for (int n = 0; n < NSTEPS; n++) begin
            rst         = (n < 5) || (n == 155) || (n == 262);
            restart_req = (n == 105) || (n == 142) || (n == 241) || (n == 245) || (n == 262);
            hold        = (n >= 181) && (n <= 187);
            if (rst || restart_req) begin
                k    = 0;
                held = 0;
            end else begin
                calc(k, held, 2, 50, BIG, st, ch, cnt);
                if (HOLD_EN && hold && st == 2'd2) held++;
                k++;
            end
            e.step = n;
            calc(k, held, 2, 50, BIG, e.st_a, e.ch_a, e.cnt_a);
            calc(k, 0, 0, 0, 15, e.st_b, e.ch_b, e.cnt_b);
            q.push_back(e);
            @(negedge clk);
        end
        repeat (2) @(negedge clk);
        check("queue_drain", -1, q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
